// File: rtl/ldl_pipe_ctrl_pkg.sv
// Shared types and helpers for the LDL pipeline controller:
// the drain FSM state encoding and the occupancy-counter width function.
package ldl_pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Smallest number of bits that can index 'value' distinct values.
   // Called with LEVEL+1 so that the counter can hold 0..LEVEL.
   function automatic int clog2(input int value);
      int result;
      int span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span * 2;
         result = result + 1;
      end
      return result;
   endfunction

endpackage : ldl_pipe_ctrl_pkg

// File: rtl/ldl_pipe_ctrl_if.sv
// Handshake, control and status bundle of the LDL pipeline controller.
// master = the environment (upstream source, downstream sink, control),
// slave  = the pipeline controller itself.
interface ldl_pipe_ctrl_if #(
   parameter int WIDTH = 1,
   parameter int LEVEL = 1
);
   import ldl_pipe_ctrl_pkg::*;

   localparam int CNT_W = clog2(LEVEL + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             flush;
   logic             drain;
   logic             drain_done;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;

   modport master (
      output in_valid, in_data, out_ready, flush, drain,
      input  in_ready, out_valid, out_data, drain_done, count, empty, full
   );

   modport slave (
      input  in_valid, in_data, out_ready, flush, drain,
      output in_ready, out_valid, out_data, drain_done, count, empty, full
   );

endinterface : ldl_pipe_ctrl_if

// File: rtl/ldl_pipe_ctrl_dff_array.sv
// Library block: a chain of LEVEL enabled WIDTH-bit registers.
// On en, stage 0 captures din and every other stage takes its predecessor;
// dout is the last stage. The reset clears the stages when used.
module ldl_dff_array_v1 #(
   parameter int WIDTH = 1,
   parameter int LEVEL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_r [LEVEL];

   // Shift the payload one stage toward the output on every enabled cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LEVEL; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
         end
      end else if (en) begin
         stage_r[0] <= din;
         for (int i = 1; i < LEVEL; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end else begin
         for (int i = 0; i < LEVEL; i++) begin
            stage_r[i] <= stage_r[i];
         end
      end
   end

   assign dout = stage_r[LEVEL-1];

endmodule : ldl_dff_array_v1

// File: rtl/ldl_pipe_ctrl.sv
// LDL pipeline controller: a LEVEL-deep valid/ready register pipeline.
// Per-stage valid bits move together with the payload whenever the last
// stage is free or being taken. A small FSM stops intake on drain and pulses
// drain_done once the pipe is empty; flush and rst discard everything.
module ldl_pipe_ctrl
   import ldl_pipe_ctrl_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int LEVEL = 1
) (
   input  logic          clk,
   input  logic          rst,
   ldl_pipe_ctrl_if.slave bus
);

   localparam int CNT_W = clog2(LEVEL + 1);

   logic [LEVEL-1:0] vld_r;
   logic [LEVEL-1:0] vld_nxt_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic             empty_r;
   logic             full_r;
   logic             drain_done_r;
   state_t           state_r;
   logic             adv_s;
   logic             in_ready_s;
   logic             accept_s;

   // Number of set bits in an occupancy vector.
   function automatic logic [CNT_W-1:0] popcount(input logic [LEVEL-1:0] bits);
      logic [CNT_W-1:0] total;
      total = {CNT_W{1'b0}};
      for (int i = 0; i < LEVEL; i++) begin
         total = total + CNT_W'(bits[i]);
      end
      return total;
   endfunction

   // Pipe moves when the output stage is empty or downstream takes it;
   // intake only in RUN, never while flushing or in reset
   always_comb begin
      adv_s      = !vld_r[LEVEL-1] || bus.out_ready;
      in_ready_s = adv_s && (state_r == RUN) && !bus.flush && !rst;
      accept_s   = bus.in_valid && in_ready_s;
   end

   // Next occupancy: cleared on flush/rst, shifted on advance, else held
   always_comb begin
      vld_nxt_s = vld_r;
      if (rst || bus.flush) begin
         vld_nxt_s = {LEVEL{1'b0}};
      end else if (adv_s) begin
         vld_nxt_s[0] = accept_s;
         for (int i = 1; i < LEVEL; i++) begin
            vld_nxt_s[i] = vld_r[i-1];
         end
      end else begin
         vld_nxt_s = vld_r;
      end
      count_nxt_s = popcount(vld_nxt_s);
   end

   // Occupancy register with count/empty/full kept in step with it
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_r   <= {LEVEL{1'b0}};
         count_r <= {CNT_W{1'b0}};
         empty_r <= 1'b1;
         full_r  <= 1'b0;
      end else begin
         vld_r   <= vld_nxt_s;
         count_r <= count_nxt_s;
         empty_r <= (count_nxt_s == {CNT_W{1'b0}});
         full_r  <= (count_nxt_s == CNT_W'(LEVEL));
      end
   end

   // Drain sequencing: stop intake, wait for an empty pipe, pulse done once
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= RUN;
         drain_done_r <= 1'b0;
      end else if (bus.flush) begin
         state_r      <= RUN;
         drain_done_r <= 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               if (bus.drain) begin
                  state_r <= DRAIN;
               end else begin
                  state_r <= RUN;
               end
               drain_done_r <= 1'b0;
            end
            DRAIN: begin
               if (count_r == {CNT_W{1'b0}}) begin
                  state_r      <= DONE;
                  drain_done_r <= 1'b1;
               end else begin
                  state_r      <= DRAIN;
                  drain_done_r <= 1'b0;
               end
            end
            DONE: begin
               state_r      <= RUN;
               drain_done_r <= 1'b0;
            end
            default: begin
               state_r      <= RUN;
               drain_done_r <= 1'b0;
            end
         endcase
      end
   end

   // Payload stages follow the valid bits; they are never cleared because
   // bubble data is don't-care
   ldl_dff_array_v1 #(
      .WIDTH (WIDTH),
      .LEVEL (LEVEL)
   ) u_data (
      .clk  (clk),
      .rst  (1'b0),
      .en   (adv_s),
      .din  (bus.in_data),
      .dout (bus.out_data)
   );

   // A beat sitting in the output stage is not offered while rst is high,
   // so reset never completes an output handshake
   assign bus.in_ready   = in_ready_s;
   assign bus.out_valid  = vld_r[LEVEL-1] & ~rst;
   assign bus.count      = count_r;
   assign bus.empty      = empty_r;
   assign bus.full       = full_r;
   assign bus.drain_done = drain_done_r;

endmodule : ldl_pipe_ctrl

// File: tb/tb_ldl_pipe_ctrl.sv
// Bench for ldl_pipe_ctrl: three instances (LEVEL 4, 3, 1) share one
// stimulus stream. A slot-list reference model per instance predicts every
// output each cycle; vector tables and short sequences pin down latency,
// backpressure, flush, drain and reset corners.
module tb_ldl_pipe_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic         flush;
   logic         drain;
   logic [W-1:0] in_data;

   ldl_pipe_ctrl_if #(.WIDTH(W), .LEVEL(4)) bus4 ();
   ldl_pipe_ctrl_if #(.WIDTH(W), .LEVEL(3)) bus3 ();
   ldl_pipe_ctrl_if #(.WIDTH(W), .LEVEL(1)) bus1 ();

   assign bus4.in_valid = in_valid;  assign bus4.in_data = in_data;
   assign bus4.out_ready = out_ready; assign bus4.flush = flush; assign bus4.drain = drain;
   assign bus3.in_valid = in_valid;  assign bus3.in_data = in_data;
   assign bus3.out_ready = out_ready; assign bus3.flush = flush; assign bus3.drain = drain;
   assign bus1.in_valid = in_valid;  assign bus1.in_data = in_data;
   assign bus1.out_ready = out_ready; assign bus1.flush = flush; assign bus1.drain = drain;

   ldl_pipe_ctrl #(.WIDTH(W), .LEVEL(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   ldl_pipe_ctrl #(.WIDTH(W), .LEVEL(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
   ldl_pipe_ctrl #(.WIDTH(W), .LEVEL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Observed outputs, index 0 = LEVEL 4, 1 = LEVEL 3, 2 = LEVEL 1
   logic         ov  [3];
   logic [W-1:0] od  [3];
   logic [2:0]   cnt [3];
   logic         emp [3];
   logic         ful [3];
   logic         dd  [3];
   logic         ir  [3];

   assign ov[0] = bus4.out_valid; assign od[0] = bus4.out_data; assign cnt[0] = 3'(bus4.count);
   assign emp[0] = bus4.empty; assign ful[0] = bus4.full; assign dd[0] = bus4.drain_done;
   assign ir[0] = bus4.in_ready;
   assign ov[1] = bus3.out_valid; assign od[1] = bus3.out_data; assign cnt[1] = 3'(bus3.count);
   assign emp[1] = bus3.empty; assign ful[1] = bus3.full; assign dd[1] = bus3.drain_done;
   assign ir[1] = bus3.in_ready;
   assign ov[2] = bus1.out_valid; assign od[2] = bus1.out_data; assign cnt[2] = 3'(bus1.count);
   assign emp[2] = bus1.empty; assign ful[2] = bus1.full; assign dd[2] = bus1.drain_done;
   assign ir[2] = bus1.in_ready;

   int checks = 0;
   int errors = 0;

   // Reference model: each pipe is a list of lvl slots, slot 0 at the
   // output end. Drain phase: 0 = running, 1 = draining, 2 = done pulse.
   int           lvl [3] = '{4, 3, 1};
   logic         mv  [3][4];
   logic [W-1:0] md  [3][4];
   int           mph [3];

   task automatic chk(input string name, input int d, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (LEVEL %0d) got %0h expected %0h at %0t",
                  name, lvl[d], act, exp, $time);
      end
   endtask

   function automatic int m_count(input int d);
      int n;
      n = 0;
      for (int i = 0; i < lvl[d]; i++) n += int'(mv[d][i]);
      return n;
   endfunction

   function automatic logic m_in_ready(input int d);
      return (!mv[d][0] || out_ready) && (mph[d] == 0) && !flush && !rst;
   endfunction

   // Apply one clock edge to every model using the inputs held this cycle
   task automatic m_clock();
      logic take;
      logic acc;
      int   c;
      for (int d = 0; d < 3; d++) begin
         take = !mv[d][0] || out_ready;
         acc  = in_valid && m_in_ready(d);
         c    = m_count(d);
         if (rst || flush) begin
            for (int i = 0; i < 4; i++) mv[d][i] = 1'b0;
         end else if (take) begin
            // the oldest slot leaves, a new slot (beat or bubble) joins
            for (int i = 0; i < lvl[d] - 1; i++) begin
               mv[d][i] = mv[d][i+1];
               md[d][i] = md[d][i+1];
            end
            mv[d][lvl[d]-1] = acc;
            md[d][lvl[d]-1] = in_data;
         end
         if (rst || flush) mph[d] = 0;
         else if (mph[d] == 0) mph[d] = drain ? 1 : 0;
         else if (mph[d] == 1) mph[d] = (c == 0) ? 2 : 1;
         else mph[d] = 0;
      end
   endtask

   task automatic check_regs();
      int c;
      for (int d = 0; d < 3; d++) begin
         c = m_count(d);
         chk("out_valid", d, 32'(ov[d]), 32'(mv[d][0]));
         if (mv[d][0]) chk("out_data", d, 32'(od[d]), 32'(md[d][0]));
         chk("count", d, 32'(cnt[d]), 32'(c));
         chk("empty", d, 32'(emp[d]), 32'(c == 0));
         chk("full", d, 32'(ful[d]), 32'(c == lvl[d]));
         chk("drain_done", d, 32'(dd[d]), 32'(mph[d] == 2));
      end
   endtask

   // One cycle: inputs were set at the preceding negedge
   task automatic step();
      #1;
      for (int d = 0; d < 3; d++) chk("in_ready", d, 32'(ir[d]), 32'(m_in_ready(d)));
      @(posedge clk);
      m_clock();
      @(negedge clk);
      check_regs();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; drain = 1'b0; rst = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   typedef struct {
      logic         iv;
      logic [W-1:0] id;
      logic         ordy;
      logic         ov;
      logic [W-1:0] od;
      logic [2:0]   cnt;
      logic         full;
      logic         irdy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic iv, input logic [W-1:0] id, input logic ordy,
                               input logic ov_e, input logic [W-1:0] od_e, input int cnt_e,
                               input logic full_e, input logic irdy_e);
      vec_t v;
      v.iv = iv; v.id = id; v.ordy = ordy; v.ov = ov_e; v.od = od_e;
      v.cnt = 3'(cnt_e); v.full = full_e; v.irdy = irdy_e;
      return v;
   endfunction

   int got;
   int pulses;
   int leaks;
   logic seen;

   initial begin
      for (int d = 0; d < 3; d++) begin
         mph[d] = 0;
         for (int i = 0; i < 4; i++) begin
            mv[d][i] = 1'b0;
            md[d][i] = '0;
         end
      end
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; drain = 1'b0;
      step();
      step();
      for (int d = 0; d < 3; d++) begin
         chk("reset_valid", d, 32'(ov[d]), 32'd0);
         chk("reset_count", d, 32'(cnt[d]), 32'd0);
         chk("reset_empty", d, 32'(emp[d]), 32'd1);
      end
      rst = 1'b0;

      // LEVEL 4 streaming: beat k+1 offered in row k, seen 4 rows later,
      // one per row with out_ready held high
      for (int k = 0; k < 14; k++) begin
         int c;
         c = 0;
         for (int j = 1; j <= 8; j++) if (j <= k && k <= j + 3) c++;
         tbl.push_back(mk(k < 8, 8'(k + 1), 1'b1, (k >= 4 && k <= 11), 8'(k - 3), c,
                          c == 4, 1'b1));
      end
      // LEVEL 4 backpressure: fill, freeze while out_ready=0, then release
      tbl.push_back(mk(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 8'hA3, 1'b0, 1'b0, 8'h00, 2, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 8'hA4, 1'b0, 1'b0, 8'h00, 3, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 8'h55, 1'b0, 1'b1, 8'hA1, 4, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 8'h56, 1'b0, 1'b1, 8'hA1, 4, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 4, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 3, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 2, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1));

      for (int k = 0; k < tbl.size(); k++) begin
         chk("tbl_out_valid", 0, 32'(ov[0]), 32'(tbl[k].ov));
         if (tbl[k].ov) chk("tbl_out_data", 0, 32'(od[0]), 32'(tbl[k].od));
         chk("tbl_count", 0, 32'(cnt[0]), 32'(tbl[k].cnt));
         chk("tbl_full", 0, 32'(ful[0]), 32'(tbl[k].full));
         in_valid = tbl[k].iv; in_data = tbl[k].id; out_ready = tbl[k].ordy;
         flush = 1'b0; drain = 1'b0;
         #1;
         chk("tbl_in_ready", 0, 32'(ir[0]), 32'(tbl[k].irdy));
         step();
      end
      idle(6);

      // LEVEL 3 flush with two beats in flight, then normal traffic
      in_valid = 1'b1; in_data = 8'h21; step();
      in_data = 8'h22; step();
      flush = 1'b1; in_data = 8'h23; step();
      chk("flush_count", 1, 32'(cnt[1]), 32'd0);
      chk("flush_empty", 1, 32'(emp[1]), 32'd1);
      flush = 1'b0; in_data = 8'h31; step();
      in_valid = 1'b0; step();
      step();
      chk("post_flush_valid", 1, 32'(ov[1]), 32'd1);
      chk("post_flush_data", 1, 32'(od[1]), 32'h31);
      idle(6);

      // LEVEL 4 drain: in_valid stays high throughout. The FSM is still in
      // RUN in the cycle drain is raised, so that cycle carries the third beat.
      in_valid = 1'b1; in_data = 8'h41; step();
      in_data = 8'h42; step();
      in_data = 8'h43; drain = 1'b1; step();
      drain = 1'b0; in_data = 8'h44;
      got = 0; pulses = 0; leaks = 0; seen = 1'b0;
      for (int n = 0; n < 16; n++) begin
         if (dd[0]) begin
            pulses++;
            seen = 1'b1;
         end
         if (!seen && ov[0]) got++;
         if (!seen && ir[0]) leaks++;
         step();
      end
      chk("drain_beats_out", 0, 32'(got), 32'd3);
      chk("drain_done_pulses", 0, 32'(pulses), 32'd1);
      chk("drain_no_intake", 0, 32'(leaks), 32'd0);
      chk("drain_ready_back", 0, 32'(ir[0]), 32'd1);
      idle(6);

      // Drain on an empty pipe: done pulse two cycles after the request
      drain = 1'b1; step();
      drain = 1'b0;
      chk("empty_drain_t1", 0, 32'(dd[0]), 32'd0);
      step();
      chk("empty_drain_t2", 0, 32'(dd[0]), 32'd1);
      chk("empty_drain_t2_l1", 2, 32'(dd[2]), 32'd1);
      step();
      chk("empty_drain_t3", 0, 32'(dd[0]), 32'd0);

      // flush together with drain: no drain_done may follow
      in_valid = 1'b1; in_data = 8'h51;
      for (int n = 0; n < 3; n++) step();
      flush = 1'b1; drain = 1'b1; step();
      flush = 1'b0; drain = 1'b0; in_valid = 1'b0;
      pulses = 0;
      for (int n = 0; n < 5; n++) begin
         if (dd[0] || dd[1] || dd[2]) pulses++;
         step();
      end
      chk("flush_beats_drain", 0, 32'(pulses), 32'd0);

      // rst mid-stream together with flush and drain
      in_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
         in_data = 8'(8'h60 + n);
         step();
      end
      rst = 1'b1; flush = 1'b1; drain = 1'b1; step();
      rst = 1'b0; flush = 1'b0; drain = 1'b0; in_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk("rst_mid_valid", d, 32'(ov[d]), 32'd0);
         chk("rst_mid_count", d, 32'(cnt[d]), 32'd0);
         chk("rst_mid_done", d, 32'(dd[d]), 32'd0);
      end
      step();
      chk("rst_mid_done_next", 0, 32'(dd[0]), 32'd0);

      // Randomised traffic against the model
      for (int n = 0; n < 1500; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         drain     = ($urandom_range(0, 15) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         step();
      end
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ldl_pipe_ctrl

// File: doc/ldl_pipe_ctrl.md
LDL_PIPE_CTRL -- requirements
Module: LDL_pipe_ctrl

Interface
REQ-001 Parameter WIDTH, default 1: data bits per stage; SHALL be >= 1.
REQ-002 Parameter LEVEL, default 1: number of register stages (latency); SHALL be >= 1.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block accepts the upstream beat this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  last stage holds a valid beat.
REQ-009 out_ready  input  1  downstream accepts the beat.
REQ-010 out_data  output  WIDTH  last-stage payload; meaningful only when out_valid=1.
REQ-011 flush  input  1  discard all in-flight beats.
REQ-012 drain  input  1  request to stop intake and empty the pipeline.
REQ-013 drain_done  output  1  single-cycle pulse when a drain completes.
REQ-014 count  output  $clog2(LEVEL+1)  number of valid beats in flight.
REQ-015 empty / full  output  1 each  count==0 / count==LEVEL.

Function
REQ-016 Per-stage valid bits vld[LEVEL-1:0] SHALL track occupancy; vld[LEVEL-1] SHALL drive out_valid.
REQ-017 Advance condition adv = !vld[LEVEL-1] || out_ready, combinational, with no registered ready path.
REQ-018 On adv, vld SHALL shift one stage toward the output, and stage 0 SHALL load (in_valid && in_ready).
REQ-019 On adv, data stages SHALL shift together with vld; stage 0 SHALL load in_data unconditionally. Bubble data is don't-care.
REQ-020 When adv=0, all vld and data stages SHALL hold.
REQ-021 in_ready SHALL equal adv && state==RUN && !flush.
REQ-022 With no backpressure, a beat accepted in cycle N SHALL appear with out_valid=1 in cycle N+LEVEL.
REQ-023 Beat order SHALL be preserved. A beat SHALL never be duplicated or dropped, except by flush.
REQ-024 Consecutive accepted beats with constant out_ready=1 SHALL achieve a throughput of 1 beat/cycle.
REQ-025 count SHALL equal the popcount of vld, registered so that it is consistent with vld every cycle.
REQ-026 FSM states are RUN, DRAIN and DONE.
REQ-027 RUN -> DRAIN when drain=1 and flush=0.
REQ-028 DRAIN: in_ready=0 and the pipeline keeps advancing per REQ-017; DRAIN -> DONE in the cycle after count reaches 0.
REQ-029 DONE: drain_done=1 for exactly one cycle, then the FSM returns to RUN regardless of the drain level.
REQ-030 A drain request while already empty SHALL go RUN -> DRAIN -> DONE, giving drain_done two cycles after drain is asserted.
REQ-031 flush=1 SHALL clear all vld bits next cycle, block acceptance that cycle and force state RUN; flush SHALL win over drain, adv and out_ready.
REQ-032 If flush=1 while out_valid=1 and out_ready=1, the output handshake SHALL still complete that cycle; all other beats are discarded.
REQ-033 If flush and drain are asserted together, flush SHALL win and no drain_done SHALL be produced.

Reset
REQ-034 rst SHALL set vld=0, count=0, state=RUN and drain_done=0, giving out_valid=0, empty=1, full=0; rst SHALL override flush and drain.
REQ-035 Data stages SHALL NOT be reset.
REQ-036 rst asserted mid-operation SHALL discard all beats exactly as flush does, with no output handshake that cycle.

Structure
REQ-037 Package LDL_pipe_ctrl_pkg SHALL hold the FSM state enum (RUN/DRAIN/DONE) and a count-width function clog2(LEVEL+1).
REQ-038 The data path SHALL be one instance of the existing library block LDL_dff_array_v1 (WIDTH, LEVEL), with en=adv and rst tied to 0.
REQ-039 The valid/occupancy logic and FSM SHALL remain in LDL_pipe_ctrl.

Verification
REQ-040 LEVEL=4, out_ready=1, beats 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on consecutive cycles, the first exactly 4 cycles after acceptance.
REQ-041 LEVEL=4, 4 beats, out_ready=0 -> full=1, count=4, in_ready=0, stages frozen; release out_ready -> beats emerge in order at 1/cycle.
REQ-042 LEVEL=3, 2 beats in flight, pulse flush -> next cycle count=0 and empty=1; beats sent afterwards emerge normally.
REQ-043 LEVEL=4, 3 beats in flight, pulse drain with in_valid held 1 -> no new acceptance, 3 beats emerge, then a single drain_done pulse, then in_ready returns to 1.
REQ-044 Assert rst mid-stream and together with flush and drain -> out_valid=0, count=0, no drain_done; LEVEL=1 smoke test passes REQ-040 with 1-cycle latency.
